// File: rtl/arm_control_sequencer_if.sv
// ---------------------------------------------------------------------------
// arm_control_sequencer_if
// Groups the signals between the control sequencer, the instruction memory /
// IR, and the RF + barrel shifter + ALU datapath.
//
// Inputs to the sequencer:
//   IR        [31:0]  current instruction register contents
//   FLAGS_OUT [3:0]   ALU status {N,Z,C,V}
//   MFC               memory function complete
// Outputs from the sequencer:
//   MFA               memory function activate (instruction read)
//   IR_LD             load IR from the memory data bus
//   LOAD              register file write enable
//   LOADPC            PC write enable
//   PCSRC             PC source: 0 = PC+4, 1 = branch target
//   IR_CU             1 = RF selects from IR fields, 0 = from RSLCT
//   RSLCT     [19:0]  CU register selects {Rn copy, Rd, Rs, Rm, Rn}
//   OP        [4:0]   ALU operation
//   S                 ALU flag update enable
//   ALU_OUT           ALU output drive enable
//   UNDEF             one-cycle pulse on an unsupported instruction class
//   ABORT             fetch timeout, held until reset
//
// Modports: master = the sequencer, slave = the datapath/memory side.
// ---------------------------------------------------------------------------
interface arm_control_sequencer_if;
    logic [31:0] IR;
    logic [3:0]  FLAGS_OUT;
    logic        MFC;
    logic        MFA;
    logic        IR_LD;
    logic        LOAD;
    logic        LOADPC;
    logic        PCSRC;
    logic        IR_CU;
    logic [19:0] RSLCT;
    logic [4:0]  OP;
    logic        S;
    logic        ALU_OUT;
    logic        UNDEF;
    logic        ABORT;

    modport master (
        input  IR, FLAGS_OUT, MFC,
        output MFA, IR_LD, LOAD, LOADPC, PCSRC, IR_CU, RSLCT, OP, S,
               ALU_OUT, UNDEF, ABORT
    );

    modport slave (
        output IR, FLAGS_OUT, MFC,
        input  MFA, IR_LD, LOAD, LOADPC, PCSRC, IR_CU, RSLCT, OP, S,
               ALU_OUT, UNDEF, ABORT
    );
endinterface

// File: rtl/arm_control_sequencer.sv
// ---------------------------------------------------------------------------
// arm_control_sequencer
// Multi-cycle Moore control unit for the RF + barrel shifter + ARM_ALU
// datapath. It fetches an instruction over the MFA/MFC handshake, has the IR
// loaded, checks the ARM condition field against the ALU flags and then runs
// a one-cycle data-processing or branch step.
//
// Ports:
//   Clk    system clock, state advances on the rising edge
//   RESET  asynchronous active-high reset; forces FETCH and zeroes outputs
//   bus    arm_control_sequencer_if.master (instruction/flags in, controls out)
//
// Parameter:
//   MFC_TIMEOUT  cycles allowed in WAIT_MFC without MFC before ABORT (1-255)
// ---------------------------------------------------------------------------
module arm_control_sequencer #(
    parameter int MFC_TIMEOUT = 15
) (
    input  logic                           Clk,
    input  logic                           RESET,
    arm_control_sequencer_if.master        bus
);

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_WAIT_MFC,
        ST_LATCH_IR,
        ST_DECODE,
        ST_EXEC_DP,
        ST_BRANCH,
        ST_ABORT
    } state_t;

    localparam logic [7:0] TIMEOUT_COUNT = 8'(MFC_TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cnt_inc;
    logic        cond_pass;
    logic        flag_n, flag_z, flag_c, flag_v;
    logic        is_dp, is_branch, is_compare;

    logic        mfa, ir_ld, load, loadpc, pcsrc, ir_cu;
    logic [19:0] rslct;
    logic [4:0]  op;
    logic        s, alu_out, undef, abort;

    assign flag_n     = bus.FLAGS_OUT[3];
    assign flag_z     = bus.FLAGS_OUT[2];
    assign flag_c     = bus.FLAGS_OUT[1];
    assign flag_v     = bus.FLAGS_OUT[0];
    assign is_dp      = (bus.IR[27:26] == 2'b00);
    assign is_branch  = (bus.IR[27:25] == 3'b101);
    // TST/TEQ/CMP/CMN (opcodes 8..11) only set flags and never write back.
    assign is_compare = (bus.IR[24:23] == 2'b10);
    assign cnt_inc    = cnt_q + 8'd1;

    // ARM condition code evaluation; 1111 is treated as "never".
    always_comb begin
        cond_pass = 1'b0;
        unique case (bus.IR[31:28])
            4'h0:    cond_pass = flag_z;
            4'h1:    cond_pass = !flag_z;
            4'h2:    cond_pass = flag_c;
            4'h3:    cond_pass = !flag_c;
            4'h4:    cond_pass = flag_n;
            4'h5:    cond_pass = !flag_n;
            4'h6:    cond_pass = flag_v;
            4'h7:    cond_pass = !flag_v;
            4'h8:    cond_pass = flag_c && !flag_z;
            4'h9:    cond_pass = !flag_c || flag_z;
            4'hA:    cond_pass = (flag_n == flag_v);
            4'hB:    cond_pass = (flag_n != flag_v);
            4'hC:    cond_pass = !flag_z && (flag_n == flag_v);
            4'hD:    cond_pass = flag_z || (flag_n != flag_v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_FETCH;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and Moore outputs. RESET gates the outputs combinationally so
    // they drop to zero the instant it rises, even mid-instruction.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mfa     = 1'b0;
        ir_ld   = 1'b0;
        load    = 1'b0;
        loadpc  = 1'b0;
        pcsrc   = 1'b0;
        ir_cu   = 1'b0;
        rslct   = 20'd0;
        op      = 5'd0;
        s       = 1'b0;
        alu_out = 1'b0;
        undef   = 1'b0;
        abort   = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                mfa     = 1'b1;
                // PC (R15) drives the memory address via Rn and its copy.
                rslct   = {4'hF, 12'h000, 4'hF};
                cnt_d   = 8'd0;
                state_d = ST_WAIT_MFC;
            end
            ST_WAIT_MFC: begin
                mfa = 1'b1;
                // MFC is checked first so it wins over a simultaneous timeout.
                if (bus.MFC) begin
                    state_d = ST_LATCH_IR;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc >= TIMEOUT_COUNT) begin
                        state_d = ST_ABORT;
                    end
                end
            end
            ST_LATCH_IR: begin
                ir_ld   = 1'b1;
                loadpc  = 1'b1;
                cnt_d   = 8'd0;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_cu = 1'b1;
                if (!cond_pass) begin
                    state_d = ST_FETCH;
                end else if (is_dp) begin
                    state_d = ST_EXEC_DP;
                end else if (is_branch) begin
                    state_d = ST_BRANCH;
                end else begin
                    undef   = 1'b1;
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC_DP: begin
                ir_cu   = 1'b1;
                alu_out = 1'b1;
                op      = {1'b0, bus.IR[24:21]};
                s       = bus.IR[20] | is_compare;
                load    = !is_compare;
                state_d = ST_FETCH;
            end
            ST_BRANCH: begin
                loadpc  = 1'b1;
                pcsrc   = 1'b1;
                state_d = ST_FETCH;
            end
            ST_ABORT: begin
                abort = 1'b1;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (RESET) begin
            mfa     = 1'b0;
            ir_ld   = 1'b0;
            load    = 1'b0;
            loadpc  = 1'b0;
            pcsrc   = 1'b0;
            ir_cu   = 1'b0;
            rslct   = 20'd0;
            op      = 5'd0;
            s       = 1'b0;
            alu_out = 1'b0;
            undef   = 1'b0;
            abort   = 1'b0;
        end
    end

    assign bus.MFA     = mfa;
    assign bus.IR_LD   = ir_ld;
    assign bus.LOAD    = load;
    assign bus.LOADPC  = loadpc;
    assign bus.PCSRC   = pcsrc;
    assign bus.IR_CU   = ir_cu;
    assign bus.RSLCT   = rslct;
    assign bus.OP      = op;
    assign bus.S       = s;
    assign bus.ALU_OUT = alu_out;
    assign bus.UNDEF   = undef;
    assign bus.ABORT   = abort;

endmodule

// File: tb/tb_arm_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_arm_control_sequencer
// Scoreboard bench for arm_control_sequencer. The stimulus side computes the
// per-cycle control outputs each instruction should produce and queues them;
// a monitor on the falling edge pops and compares whenever the sequencer
// presents any active output.
// ---------------------------------------------------------------------------
module tb_arm_control_sequencer;

    localparam int TIMEOUT   = 15;
    localparam int ABORT_LEN = 20;

    logic Clk = 1'b0;
    logic RESET;

    arm_control_sequencer_if bus ();

    arm_control_sequencer #(.MFC_TIMEOUT(TIMEOUT)) dut (
        .Clk   (Clk),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic        mfa;
        logic        ir_ld;
        logic        load;
        logic        loadpc;
        logic        pcsrc;
        logic        ir_cu;
        logic [19:0] rslct;
        logic [4:0]  op;
        logic        s;
        logic        alu_out;
        logic        undef;
        logic        abort;
    } outv_t;

    outv_t expQ[$];
    outv_t plan[$];
    int    assertCount = 0;
    int    failCount   = 0;

    function automatic outv_t sampleDut();
        outv_t v;
        v.mfa     = bus.MFA;
        v.ir_ld   = bus.IR_LD;
        v.load    = bus.LOAD;
        v.loadpc  = bus.LOADPC;
        v.pcsrc   = bus.PCSRC;
        v.ir_cu   = bus.IR_CU;
        v.rslct   = bus.RSLCT;
        v.op      = bus.OP;
        v.s       = bus.S;
        v.alu_out = bus.ALU_OUT;
        v.undef   = bus.UNDEF;
        v.abort   = bus.ABORT;
        return v;
    endfunction

    // ARM conditions come in true/inverted pairs: cond[3:1] picks the base
    // predicate, cond[0] inverts it. 111x is always / never.
    function automatic bit condHolds(input logic [3:0] cond, input logic [3:0] flags);
        bit n, z, c, v, base;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return (cond[0] == 1'b0);
        endcase
        return cond[0] ? !base : base;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Expected per-cycle outputs of one instruction, from FETCH onwards.
    task automatic buildPlan(input logic [31:0] ir, input logic [3:0] flags, input int w);
        outv_t f, wt, v;
        bit ok, dp, br, cmp;
        plan.delete();
        f = '0;
        f.mfa = 1'b1;
        f.rslct = {4'hF, 12'h000, 4'hF};
        plan.push_back(f);
        wt = '0;
        wt.mfa = 1'b1;
        if (w >= TIMEOUT) begin
            repeat (TIMEOUT) plan.push_back(wt);
            v = '0;
            v.abort = 1'b1;
            repeat (ABORT_LEN) plan.push_back(v);
            return;
        end
        repeat (w + 1) plan.push_back(wt);
        v = '0;
        v.ir_ld = 1'b1;
        v.loadpc = 1'b1;
        plan.push_back(v);
        ok = condHolds(ir[31:28], flags);
        dp = (ir[27:26] == 2'b00);
        br = (ir[27:25] == 3'b101);
        v = '0;
        v.ir_cu = 1'b1;
        v.undef = ok && !dp && !br;
        plan.push_back(v);
        if (ok && dp) begin
            cmp = (ir[24:21] >= 4'd8) && (ir[24:21] <= 4'd11);
            v = '0;
            v.ir_cu = 1'b1;
            v.alu_out = 1'b1;
            v.op = {1'b0, ir[24:21]};
            v.s = ir[20] || cmp;
            v.load = !cmp;
            plan.push_back(v);
        end else if (ok && br) begin
            v = '0;
            v.loadpc = 1'b1;
            v.pcsrc = 1'b1;
            plan.push_back(v);
        end
    endtask

    // Called just after a rising edge with the DUT in FETCH. Runs 'keep'
    // cycles (all planned cycles when keep < 0); MFC rises after w wait cycles.
    task automatic applyStimulus(input logic [31:0] ir, input logic [3:0] flags,
                                 input int w, input int keep);
        int n;
        buildPlan(ir, flags, w);
        n = (keep < 0) ? plan.size() : keep;
        bus.IR = ir;
        bus.FLAGS_OUT = flags;
        bus.MFC = 1'b0;
        for (int i = 0; i < n; i++) expQ.push_back(plan[i]);
        for (int i = 0; i < n; i++) begin
            bus.MFC = (w < TIMEOUT) && (i == w + 1);
            @(posedge Clk);
            #1;
        end
        bus.MFC = 1'b0;
        checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
        expQ.delete();
    endtask

    // Monitor: every state drives at least one output high, so any nonzero
    // output vector is a presented cycle to be matched against the queue.
    always @(negedge Clk) begin
        outv_t act, exp;
        if (!RESET) begin
            act = sampleDut();
            if (act != '0) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected output", 64'(act), 64'd0);
                end else begin
                    exp = expQ.pop_front();
                    checkOutput("cycle outputs", 64'(act), 64'(exp));
                end
            end
        end
    end

    initial begin
        logic [31:0] ir;
        logic [3:0]  flags;
        int          w;

        RESET = 1'b1;
        bus.IR = '0;
        bus.FLAGS_OUT = '0;
        bus.MFC = 1'b0;
        @(posedge Clk);
        #1;
        checkOutput("reset outputs", 64'(sampleDut()), 64'd0);
        @(posedge Clk);
        #1;
        RESET = 1'b0;

        $display("[TB] directed instructions");
        applyStimulus(32'hE0802001, 4'b0000, 2, -1);
        applyStimulus(32'hE1500001, 4'b0000, 0, -1);
        applyStimulus(32'h00812002, 4'b0000, 0, -1);
        applyStimulus(32'h00812002, 4'b0100, 1, -1);
        applyStimulus(32'hEA000010, 4'b0000, 0, -1);
        applyStimulus(32'hEC000000, 4'b0000, 0, -1);
        applyStimulus(32'hE0802001, 4'b1010, TIMEOUT - 1, -1);

        $display("[TB] randomized instructions");
        for (int k = 0; k < 40; k++) begin
            ir = $urandom();
            case ($urandom_range(0, 3))
                0: ir[27:26] = 2'b00;
                1: ir[27:25] = 3'b101;
                2: ir[27:25] = ($urandom_range(0, 1) == 0) ? 3'b100 : 3'b011;
                default: ;
            endcase
            flags = 4'($urandom_range(0, 15));
            w = ($urandom_range(0, 9) == 0) ? TIMEOUT - 1 : $urandom_range(0, 4);
            applyStimulus(ir, flags, w, -1);
        end

        $display("[TB] reset during EXEC_DP");
        applyStimulus(32'hE0802001, 4'b0000, 0, 4);
        checkOutput("exec load before reset", 64'(bus.LOAD), 64'd1);
        RESET = 1'b1;
        #1;
        checkOutput("async reset clears outputs", 64'(sampleDut()), 64'd0);
        @(posedge Clk);
        #1;
        RESET = 1'b0;
        applyStimulus(32'hE1500001, 4'b0000, 0, -1);

        $display("[TB] fetch timeout");
        applyStimulus(32'hE0802001, 4'b0000, TIMEOUT, -1);
        checkOutput("abort held", 64'(bus.ABORT), 64'd1);
        checkOutput("abort mfa low", 64'(bus.MFA), 64'd0);
        RESET = 1'b1;
        #1;
        checkOutput("reset clears abort", 64'(sampleDut()), 64'd0);
        @(posedge Clk);
        #1;
        RESET = 1'b0;
        applyStimulus(32'hEA000010, 4'b0000, 1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/arm_control_sequencer.md
Name: arm_control_sequencer

Overview:
- Multi-cycle control unit that generates every control signal the register file, barrel shifter and ARM_ALU datapath expects.
- Fetches an instruction through an MFA/MFC memory handshake and has the IR loaded.
- Evaluates the condition field against the ALU flags, then sequences data-processing or branch execution.
- Sits between instruction memory/IR and the RF+BS+ALU datapath, replacing hand-driven control stimulus.

Parameters:
MFC_TIMEOUT, 15, max cycles spent in WAIT_MFC before entering ABORT (range 1-255)

Ports:
Clk  input  1  system clock; state updates on rising edge
RESET  input  1  asynchronous, active-high reset
IR  input  32  current instruction register contents
FLAGS_OUT  input  4  ALU status {N,Z,C,V} = bits [3:0]
MFC  input  1  memory function complete
MFA  output  1  memory function activate (instruction read)
IR_LD  output  1  load IR from memory data bus
LOAD  output  1  register file write enable
LOADPC  output  1  PC write enable
PCSRC  output  1  PC input select: 0 = PC+4, 1 = branch target
IR_CU  output  1  1 = RF selects come from IR fields, 0 = from RSLCT
RSLCT  output  20  CU register selects: [3:0] Rn, [7:4] Rm, [11:8] Rs, [15:12] Rd, [19:16] copy of [3:0]
OP  output  5  ALU operation
S  output  1  ALU flag update enable
ALU_OUT  output  1  ALU output drive enable
UNDEF  output  1  one-cycle pulse on unsupported instruction class
ABORT  output  1  fetch timeout; held until RESET

Behaviour:
- Moore FSM. All outputs decode from registered state plus IR and FLAGS_OUT.
- States: FETCH, WAIT_MFC, LATCH_IR, DECODE, EXEC_DP, BRANCH, ABORT.
- RESET=1 forces FETCH asynchronously, clears the timeout counter and drives all outputs to 0 (RSLCT=0, OP=0). This applies mid-instruction as well; no partial write may follow.
- After RESET deasserts, the first rising edge moves the FSM FETCH -> WAIT_MFC.
- FETCH: MFA=1; IR_CU=0; RSLCT[3:0]=RSLCT[19:16]=15 (PC drives the address). Always goes to WAIT_MFC.
- WAIT_MFC:
  - MFA=1 held.
  - Counter increments each cycle MFC=0.
  - MFC=1 sampled -> LATCH_IR.
  - Counter reaching MFC_TIMEOUT with MFC=0 -> ABORT.
  - MFC arriving on the same edge the count reaches MFC_TIMEOUT: MFC wins.
- LATCH_IR: IR_LD=1; LOADPC=1; PCSRC=0 (PC <- PC+4). Counter cleared. Next state DECODE.
- DECODE: IR_CU=1. Condition IR[31:28] is evaluated against FLAGS_OUT with standard ARM semantics:
  - 0000 EQ Z
  - 0001 NE !Z
  - 0010 CS C
  - 0011 CC !C
  - 0100 MI N
  - 0101 PL !N
  - 0110 VS V
  - 0111 VC !V
  - 1000 HI C&!Z
  - 1001 LS !C|Z
  - 1010 GE N==V
  - 1011 LT N!=V
  - 1100 GT !Z&(N==V)
  - 1101 LE Z|(N!=V)
  - 1110 AL 1
  - 1111 treated as never.
- DECODE transitions:
  - Condition false -> FETCH; no register, PC or flag change.
  - Condition true, IR[27:26]=00 -> EXEC_DP.
  - Condition true, IR[27:25]=101 -> BRANCH; link bit ignored, R14 not written.
  - Condition true, any other class -> UNDEF=1 for this cycle, next state FETCH.
- EXEC_DP (one cycle, then FETCH):
  - IR_CU=1; ALU_OUT=1; OP={1'b0, IR[24:21]}.
  - S=IR[20], forced to 1 when IR[24:21] is in 8..11 (TST, TEQ, CMP, CMN).
  - LOAD=1 except opcodes 8..11, where LOAD=0.
  - RF write occurs on the falling edge inside this cycle.
  - IR[25] and IR[4] pass to the barrel shifter through IR unchanged; the CU does not alter the shifter mode.
- BRANCH: LOADPC=1; PCSRC=1; one cycle, then FETCH.
- ABORT: ABORT=1; all other outputs 0. Exited only by RESET.
- Latency with MFC returned in WAIT_MFC's first cycle:
  - DP instruction: 5 cycles.
  - Branch: 5 cycles.
  - Condition-failed instruction: 4 cycles.
- Unlisted outputs are 0 in every state.

Test Plan:
- RESET pulse mid-EXEC_DP (LOAD=1) -> all outputs 0 immediately (asynchronous); first edge after release shows MFA=1, FSM in WAIT_MFC.
- IR=0xE0802001 (ADD R2,R0,R1), FLAGS=0, MFC returned after 2 wait cycles -> IR_LD and LOADPC/PCSRC=0 pulse once; EXEC_DP shows OP=4, S=0, LOAD=1, ALU_OUT=1, IR_CU=1; back in FETCH 7 cycles after the start of FETCH.
- IR=0xE1500001 (CMP R0,R1) -> EXEC_DP shows OP=10, S=1, LOAD=0, ALU_OUT=1.
- IR=0x00812002 (ADDEQ) with FLAGS_OUT=4'b0000 -> DECODE returns to FETCH; LOAD, S and ALU_OUT never assert. Same IR with FLAGS_OUT=4'b0100 -> executes.
- IR=0xEA000010 (B) -> BRANCH cycle with LOADPC=1, PCSRC=1, LOAD=0; IR=0xEC000000 -> single UNDEF pulse, no writes.
- MFC held 0 for MFC_TIMEOUT=15 cycles -> ABORT=1 and MFA=0 from the next cycle, held through 20 further cycles; cleared only by RESET.
